ntt_engine: RTL and testbench

//   Banked multi-lane number-theoretic transform. LANES independent columns of ROWS 32-bit words each.
//   On start, each lane computes the length-ROWS cyclic NTT of its column modulo a prime chosen by mod_idx.
//   The host loads data through a wide row port and reads results back through the same port.
//   The block is a leaf accelerator and sits between the host memory interface and the polynomial arithmetic.

---
 rtl/ntt_pkg.sv | 53 +++++
 rtl/ntt_engine_if.sv | 37 +++
 rtl/ntt_modmul.sv | 33 +++
 rtl/ntt_engine.sv | 181 ++++++++++++++++++
 tb/tb_ntt_engine.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ntt_pkg.sv
// ntt_engine shared package: sizes, modulus/root tables,
// FSM encoding and a modular add helper.
package ntt_pkg;

  localparam int LANES = 257;
  localparam int ROWS  = 85;
  localparam int W     = 32;
  localparam int AW    = 8;
  localparam int MIW   = 6;
  localparam int NTAB  = 1 << MIW;
  localparam int CW    = $clog2(ROWS + 1);

  typedef logic [W-1:0] word_t;

  // Each (q, w) pair has w of order exactly ROWS mod prime q.
  // Unused slots hold q=0 and produce an all-zero transform.
  localparam word_t MOD_TABLE [NTAB] = '{
    0: 32'd1021,
    1: 32'd1021,
    2: 32'd1361,
    3: 32'd1021,
    5: 32'd1361,
    default: '0
  };

  localparam word_t ROOT_TABLE [NTAB] = '{
    0: 32'd12,
    1: 32'd12,
    2: 32'd208,
    3: 32'd144,
    5: 32'd1073,
    default: '0
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  // (a + b) mod q for a, b already below q.
  function automatic word_t add_mod(
    input word_t a,
    input word_t b,
    input word_t q
  );
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, q}) s = s - {1'b0, q};
    return W'(s);
  endfunction

endpackage

// File: rtl/ntt_engine_if.sv
// Host-side row port and control bundle of ntt_engine.
// Master is the host, slave is the engine.
interface ntt_engine_if;
  import ntt_pkg::*;

  logic                  start;
  logic [MIW-1:0]        mod_idx;
  logic                  mem_read;
  logic                  mem_write;
  logic [AW*LANES-1:0]   mem_addr;
  logic [W*LANES-1:0]    din;
  logic [W*LANES-1:0]    dout;
  logic                  done;

  modport master (
    output start,
    output mod_idx,
    output mem_read,
    output mem_write,
    output mem_addr,
    output din,
    input  dout,
    input  done
  );

  modport slave (
    input  start,
    input  mod_idx,
    input  mem_read,
    input  mem_write,
    input  mem_addr,
    input  din,
    output dout,
    output done
  );

endinterface

// File: rtl/ntt_modmul.sv
// Modular multiplier: p = (a*b) mod q, one register stage.
// q=0 marks an unused table slot and forces a zero result.
module ntt_modmul
  import ntt_pkg::*;
(
  input  logic  clk,
  input  word_t a_i,
  input  word_t b_i,
  input  word_t q_i,
  output word_t p_o
);

  logic [2*W-1:0] prod;
  word_t          p_d;
  word_t          p_q;

  // Full 64-bit product, fully reduced by the selected modulus.
  always_comb begin
    prod = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};
    p_d  = '0;
    if (q_i != '0) begin
      p_d = W'(prod % {{W{1'b0}}, q_i});
    end
  end

  // Result register; the pipeline depth is fixed at one.
  always_ff @(posedge clk) begin
    p_q <= p_d;
  end

  assign p_o = p_q;

endmodule

// File: rtl/ntt_engine.sv
// Banked multi-lane cyclic NTT: LANES columns of ROWS words,
// one MAC per lane per cycle, one shared twiddle datapath.
module ntt_engine
  import ntt_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  ntt_engine_if.slave bus
);

  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_LAST = CW'(ROWS);
  localparam logic [CW-1:0] K_LAST = CW'(ROWS - 1);
  localparam logic [AW-1:0] A_LIM  = AW'(ROWS);

  state_t        state_q;
  logic          done_q;
  logic [CW-1:0] c_q;
  logic [CW-1:0] k_q;
  word_t         q_q;
  word_t         w_q;
  word_t         wk_q;

  word_t tw_a;
  word_t tw_b;
  word_t tw_p;
  word_t t_cur;
  word_t wk_cur;

  logic busy;
  logic c_first;
  logic c_last;
  logic mac_vld;
  logic mac_first;

  // c counts 0..ROWS per k: ROWS MAC issues plus one wk step.
  assign busy      = state_q == ST_BUSY;
  assign c_first   = c_q == '0;
  assign c_last    = c_q == C_LAST;
  assign mac_vld   = busy && !c_first;
  assign mac_first = c_q == C_ONE;

  assign bus.done = done_q;

  // Sequencer: start/abort handling and the j/k loop counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      c_q     <= '0;
      k_q     <= '0;
      q_q     <= '0;
      w_q     <= '0;
    end else begin
      unique case (state_q)
        ST_BUSY: begin
          if (c_last) begin
            c_q <= '0;
            if (k_q == K_LAST) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              k_q <= k_q + C_ONE;
            end
          end else begin
            c_q <= c_q + C_ONE;
          end
        end
        default: begin
          if (bus.start) begin
            state_q <= ST_BUSY;
            done_q  <= 1'b0;
            c_q     <= '0;
            k_q     <= '0;
            q_q     <= MOD_TABLE[bus.mod_idx];
            w_q     <= ROOT_TABLE[bus.mod_idx];
          end
        end
      endcase
    end
  end

  // After the wk step, tw_p holds the new wk at the next c=0.
  assign wk_cur = (k_q == '0) ? W'(1) : tw_p;
  assign t_cur  = c_first ? W'(1) : tw_p;

  // Twiddle operands: seed t1=wk, step t*=wk, advance wk*=w.
  always_comb begin
    tw_a = tw_p;
    tw_b = wk_q;
    unique case (1'b1)
      c_first: begin
        tw_a = wk_cur;
        tw_b = W'(1);
      end
      c_last: begin
        tw_a = wk_q;
        tw_b = w_q;
      end
      default: ;
    endcase
  end

  // Hold wk for the whole k iteration.
  always_ff @(posedge clk) begin
    if (reset) begin
      wk_q <= '0;
    end else if (busy && c_first) begin
      wk_q <= wk_cur;
    end
  end

  ntt_modmul u_tw (
    .clk (clk),
    .a_i (tw_a),
    .b_i (tw_b),
    .q_i (q_q),
    .p_o (tw_p)
  );

  for (genvar l = 0; l < LANES; l++) begin : g_lane

    word_t         xin_q  [ROWS];
    word_t         xout_q [ROWS];
    word_t         dout_q;
    word_t         acc_q;
    word_t         acc_d;
    word_t         prod;
    word_t         x_rd;
    logic [AW-1:0] addr;
    logic [CW-1:0] ridx;
    logic [CW-1:0] xidx;
    logic          hit;

    assign addr = bus.mem_addr[AW*l +: AW];
    assign hit  = addr < A_LIM;
    assign ridx = addr[CW-1:0];
    assign xidx = c_last ? '0 : c_q;
    assign x_rd = xin_q[xidx];

    assign acc_d = add_mod(mac_first ? '0 : acc_q, prod, q_q);

    assign bus.dout[W*l +: W] = dout_q;

    ntt_modmul u_mac (
      .clk (clk),
      .a_i (x_rd),
      .b_i (t_cur),
      .q_i (q_q),
      .p_o (prod)
    );

    // Host writes into the input bank, blocked while running.
    always_ff @(posedge clk) begin
      if (bus.mem_write && !busy && hit) begin
        xin_q[ridx] <= bus.din[W*l +: W];
      end
    end

    // Accumulate one product per cycle; store XOUT[k] as j wraps.
    always_ff @(posedge clk) begin
      if (mac_vld) begin
        acc_q <= acc_d;
        if (c_last) begin
          xout_q[k_q] <= acc_d;
        end
      end
    end

    // Registered row-port read of the output bank.
    always_ff @(posedge clk) begin
      if (reset) begin
        dout_q <= '0;
      end else if (bus.mem_read) begin
        dout_q <= hit ? xout_q[ridx] : '0;
      end
    end

  end

endmodule

// File: tb/tb_ntt_engine.sv
// ntt_engine bench: directed and randomized columns compared
// against a direct O(N^2) DFT model evaluated mod q.
module tb_ntt_engine;
  import ntt_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   t0 = 0;

  logic [31:0] xin_m [LANES][ROWS];
  logic [31:0] exp_m [LANES][ROWS];

  ntt_engine_if bus ();

  ntt_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Moduli and roots of the table slots this bench uses.
  function automatic longint unsigned ref_q(input int i);
    case (i)
      0, 1, 3: return 64'd1021;
      2, 5:    return 64'd1361;
      default: return 64'd0;
    endcase
  endfunction

  function automatic longint unsigned ref_w(input int i);
    case (i)
      0, 1:    return 64'd12;
      2:       return 64'd208;
      3:       return 64'd144;
      5:       return 64'd1073;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [31:0] lane_out(input int l);
    return bus.dout[W*l +: W];
  endfunction

  // X[k] = sum_j (x[j] mod q) * w^(j*k mod N) mod q.
  task automatic model(input int mi);
    longint unsigned q;
    longint unsigned w;
    longint unsigned s;
    longint unsigned pw [ROWS];
    q = ref_q(mi);
    w = ref_w(mi);
    if (q != 0) begin
      pw[0] = 1;
      for (int e = 1; e < ROWS; e++) pw[e] = (pw[e-1] * w) % q;
    end
    for (int l = 0; l < LANES; l++) begin
      for (int k = 0; k < ROWS; k++) begin
        s = 0;
        if (q != 0) begin
          for (int j = 0; j < ROWS; j++) begin
            s = (s + ({32'b0, xin_m[l][j]} % q) * pw[(j * k) % ROWS]) % q;
          end
        end
        exp_m[l][k] = 32'(s);
      end
    end
  endtask

  task automatic idle_bus();
    bus.start     = 1'b0;
    bus.mod_idx   = '0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.din       = '0;
  endtask

  // Lane l writes row (r+l) mod ROWS in cycle r.
  task automatic load();
    int a;
    for (int r = 0; r < ROWS; r++) begin
      @(negedge clk);
      bus.mem_write = 1'b1;
      for (int l = 0; l < LANES; l++) begin
        a = (r + l) % ROWS;
        bus.mem_addr[AW*l +: AW] = AW'(a);
        bus.din[W*l +: W] = xin_m[l][a];
      end
    end
    @(negedge clk);
    bus.mem_write = 1'b0;
  endtask

  // Out-of-range write addresses must not touch any row.
  task automatic junk_write(input int base);
    @(negedge clk);
    bus.mem_write = 1'b1;
    for (int l = 0; l < LANES; l++) begin
      bus.mem_addr[AW*l +: AW] = AW'(base + (l % (256 - base)));
      bus.din[W*l +: W] = $urandom();
    end
    @(negedge clk);
    bus.mem_write = 1'b0;
  endtask

  task automatic go(input int mi);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.mod_idx = MIW'(mi);
    @(negedge clk);
    bus.start = 1'b0;
    t0 = cyc;
    check("done_clr_at_start", 64'(bus.done), 64'd0);
  endtask

  task automatic wait_done(input string tag);
    int lat;
    while (!bus.done && (cyc - t0) < 8000) @(negedge clk);
    lat = cyc - t0;
    check({tag, "_done"}, 64'(bus.done), 64'd1);
    check($sformatf("%s_latency_%0d", tag, lat),
          64'(lat >= ROWS * ROWS && lat <= 8000), 64'd1);
  endtask

  // Row reads spaced two cycles; lane l reads (k + off*l) mod ROWS.
  task automatic read_all(input string tag, input int off);
    int a;
    for (int k = 0; k < ROWS; k++) begin
      @(negedge clk);
      bus.mem_read = 1'b1;
      for (int l = 0; l < LANES; l++) begin
        bus.mem_addr[AW*l +: AW] = AW'((k + off * l) % ROWS);
      end
      @(negedge clk);
      bus.mem_read = 1'b0;
      for (int l = 0; l < LANES; l++) begin
        a = (k + off * l) % ROWS;
        check($sformatf("%s l%0d r%0d", tag, l, a),
              64'(lane_out(l)), 64'(exp_m[l][a]));
      end
    end
    @(negedge clk);
    check({tag, "_hold"}, 64'(lane_out(0)), 64'(exp_m[0][ROWS-1]));
  endtask

  task automatic read_oob(input string tag);
    @(negedge clk);
    bus.mem_read = 1'b1;
    for (int l = 0; l < LANES; l++) begin
      bus.mem_addr[AW*l +: AW] = AW'(ROWS + (l * 7) % (256 - ROWS));
    end
    @(negedge clk);
    bus.mem_read = 1'b0;
    for (int l = 0; l < LANES; l += 16) begin
      check($sformatf("%s l%0d", tag, l), 64'(lane_out(l)), 64'd0);
    end
  endtask

  task automatic fill_rand();
    for (int l = 0; l < LANES; l++)
      for (int r = 0; r < ROWS; r++)
        xin_m[l][r] = $urandom();
  endtask

  initial begin
    idle_bus();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_dout", 64'(|bus.dout), 64'd0);
    reset = 1'b0;

    // All-zero columns.
    for (int l = 0; l < LANES; l++)
      for (int r = 0; r < ROWS; r++) begin
        xin_m[l][r] = '0;
        exp_m[l][r] = '0;
      end
    load();
    go(1);
    wait_done("zero");
    read_all("zero", 0);

    // Impulse at row 0 transforms to all ones.
    for (int l = 0; l < LANES; l++)
      for (int r = 0; r < ROWS; r++) begin
        xin_m[l][r] = (r == 0) ? 32'd1 : 32'd0;
        exp_m[l][r] = 32'd1;
      end
    load();
    go(2);
    wait_done("imp");
    read_all("imp", 1);

    // Constant 5: only bin 0 survives, 85*5 = 425 < q.
    for (int l = 0; l < LANES; l++)
      for (int r = 0; r < ROWS; r++) begin
        xin_m[l][r] = 32'd5;
        exp_m[l][r] = (r == 0) ? 32'd425 : 32'd0;
      end
    load();
    go(1);
    wait_done("c5");
    read_all("c5", 0);

    // Random columns; writes and starts while busy are ignored.
    fill_rand();
    load();
    junk_write(ROWS);
    junk_write(128);
    go(2);
    repeat (300) @(negedge clk);
    bus.mem_write = 1'b1;
    for (int l = 0; l < LANES; l++) begin
      bus.mem_addr[AW*l +: AW] = AW'(200);
      bus.din[W*l +: W] = $urandom();
    end
    @(negedge clk);
    for (int l = 0; l < LANES; l++) begin
      bus.mem_addr[AW*l +: AW] = AW'(l % ROWS);
      bus.din[W*l +: W] = $urandom();
    end
    @(negedge clk);
    bus.mem_write = 1'b0;
    for (int p = 0; p < 3; p++) begin
      repeat (500) @(negedge clk);
      bus.start   = 1'b1;
      bus.mod_idx = MIW'(1);
      @(negedge clk);
      bus.start = 1'b0;
    end
    check("busy_no_done", 64'(bus.done), 64'd0);
    wait_done("rndA");
    model(2);
    read_all("rndA", 3);
    read_oob("oobA");
    check("done_level", 64'(bus.done), 64'd1);

    // Reset mid-run, then reload and rerun.
    fill_rand();
    load();
    go(5);
    repeat (1500) @(negedge clk);
    check("abort_pre_done", 64'(bus.done), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_dout", 64'(|bus.dout), 64'd0);
    fill_rand();
    load();
    check("reload_done", 64'(bus.done), 64'd0);
    go(3);
    wait_done("rndC");
    model(3);
    read_all("rndC", 2);

    // Unused table slot (q=0) gives zeros and still completes.
    go(10);
    wait_done("q0");
    model(10);
    read_all("q0", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
